// File: rtl/lazy_seq_head_controller_if.sv
// Request/summary/sequence bundle between the controller and its neighbours.
// Stats counters exist only when SEQ_CTRL_STATS_EN is defined.
interface lazy_seq_head_controller_if #(
  parameter int JOB_LEN_LOG2    = 6,
  parameter int SEQ_LL_BITS     = 8,
  parameter int SEQ_ML_BITS     = 8,
  parameter int SEQ_OFFSET_BITS = 16
);
  logic                       i_job_valid;
  logic                       o_job_ready;
  logic                       i_job_delim;
  logic                       o_match_req;
  logic [JOB_LEN_LOG2-1:0]    o_match_head_ptr;
  logic [JOB_LEN_LOG2-1:0]    o_seq_head_ptr;
  logic                       o_delim;
  logic                       i_summary_done;
  logic [SEQ_LL_BITS-1:0]     i_summary_ll;
  logic [SEQ_ML_BITS-1:0]     i_summary_ml;
  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset;
  logic                       i_summary_eoj;
  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len;
  logic [JOB_LEN_LOG2-1:0]    i_move_forward;
  logic                       o_seq_valid;
  logic                       i_seq_ready;
  logic [SEQ_LL_BITS-1:0]     o_seq_ll;
  logic [SEQ_ML_BITS-1:0]     o_seq_ml;
  logic [SEQ_OFFSET_BITS-1:0] o_seq_offset;
  logic                       o_seq_eoj;
  logic                       o_seq_delim;
  logic                       o_busy;
`ifdef SEQ_CTRL_STATS_EN
  logic [31:0]                o_stat_seq_cnt;
  logic [31:0]                o_stat_step_cnt;
  logic [31:0]                o_stat_stall_cnt;

  modport master (
    input  i_job_valid, i_job_delim, i_summary_done, i_summary_ll, i_summary_ml,
           i_summary_offset, i_summary_eoj, i_summary_overlap_len, i_move_forward,
           i_seq_ready,
    output o_job_ready, o_match_req, o_match_head_ptr, o_seq_head_ptr, o_delim,
           o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim,
           o_busy, o_stat_seq_cnt, o_stat_step_cnt, o_stat_stall_cnt
  );
  modport slave (
    output i_job_valid, i_job_delim, i_summary_done, i_summary_ll, i_summary_ml,
           i_summary_offset, i_summary_eoj, i_summary_overlap_len, i_move_forward,
           i_seq_ready,
    input  o_job_ready, o_match_req, o_match_head_ptr, o_seq_head_ptr, o_delim,
           o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim,
           o_busy, o_stat_seq_cnt, o_stat_step_cnt, o_stat_stall_cnt
  );
`else
  modport master (
    input  i_job_valid, i_job_delim, i_summary_done, i_summary_ll, i_summary_ml,
           i_summary_offset, i_summary_eoj, i_summary_overlap_len, i_move_forward,
           i_seq_ready,
    output o_job_ready, o_match_req, o_match_head_ptr, o_seq_head_ptr, o_delim,
           o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim,
           o_busy
  );
  modport slave (
    output i_job_valid, i_job_delim, i_summary_done, i_summary_ll, i_summary_ml,
           i_summary_offset, i_summary_eoj, i_summary_overlap_len, i_move_forward,
           i_seq_ready,
    input  o_job_ready, o_match_req, o_match_head_ptr, o_seq_head_ptr, o_delim,
           o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim,
           o_busy
  );
`endif
endinterface

// File: rtl/lazy_seq_head_controller.sv
// Owns per-job seq/match heads, issues one match request at a time, emits sequences.
// Latency: request 1 cycle after job accept/advance; sequence held in EMIT until i_seq_ready.
// Backpressure: stalled EMIT blocks new requests. SEQ_CTRL_STATS_EN adds saturating counters.
module lazy_seq_head_controller #(
  parameter int JOB_LEN_LOG2    = 6,
  parameter int SEQ_LL_BITS     = 8,
  parameter int SEQ_ML_BITS     = 8,
  parameter int SEQ_OFFSET_BITS = 16,
  parameter int MATCH_STEP      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  lazy_seq_head_controller_if.master bus
);
  localparam int JOB_LEN = 1 << JOB_LEN_LOG2;
  localparam int PW      = JOB_LEN_LOG2 + 1;
  // Carry must hold both an overlap length and an out-of-range pointer sum.
  localparam int CW      = (SEQ_ML_BITS > PW) ? SEQ_ML_BITS : PW;
  localparam logic [CW-1:0] JOB_LEN_C = CW'(JOB_LEN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SKIP  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4
  } state_t;

  state_t                     state_q, state_d, ret_q, ret_d;
  logic [JOB_LEN_LOG2-1:0]    seq_head_q, seq_head_d, match_head_q, match_head_d;
  logic [CW-1:0]              carry_q, carry_d;
  logic                       delim_q, delim_d;
  logic [SEQ_LL_BITS-1:0]     seq_ll_q, seq_ll_d;
  logic [SEQ_ML_BITS-1:0]     seq_ml_q, seq_ml_d;
  logic [SEQ_OFFSET_BITS-1:0] seq_off_q, seq_off_d;
  logic                       seq_eoj_q, seq_eoj_d, seq_delim_q, seq_delim_d;
  logic [PW-1:0]              sum, step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      seq_head_q   <= '0;
      match_head_q <= '0;
      carry_q      <= '0;
      delim_q      <= 1'b0;
      seq_ll_q     <= '0;
      seq_ml_q     <= '0;
      seq_off_q    <= '0;
      seq_eoj_q    <= 1'b0;
      seq_delim_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      seq_head_q   <= seq_head_d;
      match_head_q <= match_head_d;
      carry_q      <= carry_d;
      delim_q      <= delim_d;
      seq_ll_q     <= seq_ll_d;
      seq_ml_q     <= seq_ml_d;
      seq_off_q    <= seq_off_d;
      seq_eoj_q    <= seq_eoj_d;
      seq_delim_q  <= seq_delim_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    seq_head_d   = seq_head_q;
    match_head_d = match_head_q;
    carry_d      = carry_q;
    delim_d      = delim_q;
    seq_ll_d     = seq_ll_q;
    seq_ml_d     = seq_ml_q;
    seq_off_d    = seq_off_q;
    seq_eoj_d    = seq_eoj_q;
    seq_delim_d  = seq_delim_q;
    sum          = {1'b0, seq_head_q} + {1'b0, bus.i_move_forward};
    step         = {1'b0, match_head_q} + PW'(MATCH_STEP);

    case (state_q)
      ST_IDLE: begin
        if (bus.i_job_valid) begin
          delim_d = bus.i_job_delim;
          if (carry_q >= JOB_LEN_C) begin
            state_d = ST_SKIP;
          end else begin
            seq_head_d   = carry_q[JOB_LEN_LOG2-1:0];
            match_head_d = carry_q[JOB_LEN_LOG2-1:0];
            carry_d      = '0;
            state_d      = ST_ISSUE;
          end
        end
      end
      ST_SKIP: begin
        // A match spanning the whole job: consume one job's worth of carry.
        carry_d = delim_q ? '0 : carry_q - JOB_LEN_C;
        state_d = ST_IDLE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.i_summary_done) begin
          if (bus.i_summary_eoj || (bus.i_summary_ml != '0 && sum[JOB_LEN_LOG2])) begin
            // Explicit end of job, or a match running past the job end.
            seq_ll_d    = bus.i_summary_ll;
            seq_ml_d    = bus.i_summary_ml;
            seq_off_d   = bus.i_summary_offset;
            seq_eoj_d   = 1'b1;
            seq_delim_d = delim_q;
            if (delim_q)
              carry_d = '0;
            else if (bus.i_summary_eoj)
              carry_d = CW'(bus.i_summary_overlap_len);
            else
              carry_d = CW'(sum) - JOB_LEN_C;
            ret_d   = ST_IDLE;
            state_d = ST_EMIT;
          end else if (bus.i_summary_ml != '0) begin
            seq_ll_d     = bus.i_summary_ll;
            seq_ml_d     = bus.i_summary_ml;
            seq_off_d    = bus.i_summary_offset;
            seq_eoj_d    = 1'b0;
            seq_delim_d  = 1'b0;
            seq_head_d   = sum[JOB_LEN_LOG2-1:0];
            match_head_d = sum[JOB_LEN_LOG2-1:0];
            ret_d        = ST_ISSUE;
            state_d      = ST_EMIT;
          end else if (step[JOB_LEN_LOG2]) begin
            // Ran off the end with no match: flush remaining bytes as literals.
            seq_ll_d    = SEQ_LL_BITS'(JOB_LEN) - SEQ_LL_BITS'(seq_head_q);
            seq_ml_d    = '0;
            seq_off_d   = '0;
            seq_eoj_d   = 1'b1;
            seq_delim_d = delim_q;
            carry_d     = '0;
            ret_d       = ST_IDLE;
            state_d     = ST_EMIT;
          end else begin
            match_head_d = step[JOB_LEN_LOG2-1:0];
            state_d      = ST_ISSUE;
          end
        end
      end
      ST_EMIT: begin
        if (bus.i_seq_ready) state_d = ret_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_job_ready      = (state_q == ST_IDLE);
  assign bus.o_match_req      = (state_q == ST_ISSUE);
  assign bus.o_match_head_ptr = match_head_q;
  assign bus.o_seq_head_ptr   = seq_head_q;
  assign bus.o_delim          = delim_q;
  assign bus.o_seq_valid      = (state_q == ST_EMIT);
  assign bus.o_seq_ll         = seq_ll_q;
  assign bus.o_seq_ml         = seq_ml_q;
  assign bus.o_seq_offset     = seq_off_q;
  assign bus.o_seq_eoj        = seq_eoj_q;
  assign bus.o_seq_delim      = seq_delim_q;
  assign bus.o_busy           = (state_q != ST_IDLE);

`ifdef SEQ_CTRL_STATS_EN
  logic [31:0] stat_seq_q, stat_step_q, stat_stall_q;
  logic        step_evt;

  assign step_evt = (state_q == ST_WAIT) && bus.i_summary_done && !bus.i_summary_eoj &&
                    (bus.i_summary_ml == '0) && !step[JOB_LEN_LOG2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_seq_q   <= '0;
      stat_step_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (state_q == ST_EMIT && bus.i_seq_ready && stat_seq_q != '1)
        stat_seq_q <= stat_seq_q + 32'd1;
      if (step_evt && stat_step_q != '1)
        stat_step_q <= stat_step_q + 32'd1;
      if (state_q == ST_EMIT && !bus.i_seq_ready && stat_stall_q != '1)
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign bus.o_stat_seq_cnt   = stat_seq_q;
  assign bus.o_stat_step_cnt  = stat_step_q;
  assign bus.o_stat_stall_cnt = stat_stall_q;
`endif
endmodule

// File: tb/tb_lazy_seq_head_controller.sv
// Directed bench for lazy_seq_head_controller: bench plays dispatcher, pipeline and sink.
module tb_lazy_seq_head_controller;
  typedef struct packed {
    logic [7:0]  ll;
    logic [7:0]  ml;
    logic [15:0] off;
    logic        eoj;
    logic        delim;
  } seq_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  seq_t exp_q[$];

  always #5 clk = ~clk;

  lazy_seq_head_controller_if #(
    .JOB_LEN_LOG2(6), .SEQ_LL_BITS(8), .SEQ_ML_BITS(8), .SEQ_OFFSET_BITS(16)
  ) bus ();

  lazy_seq_head_controller #(
    .JOB_LEN_LOG2(6), .SEQ_LL_BITS(8), .SEQ_ML_BITS(8), .SEQ_OFFSET_BITS(16), .MATCH_STEP(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic seq_t obs_seq();
    return {bus.o_seq_ll, bus.o_seq_ml, bus.o_seq_offset, bus.o_seq_eoj, bus.o_seq_delim};
  endfunction

  task automatic start_job(input logic d);
    int k = 0;
    while (!bus.o_job_ready && k < 20) begin
      tick();
      k++;
    end
    chk("job_ready", 64'(bus.o_job_ready), 64'd1);
    bus.i_job_valid = 1'b1;
    bus.i_job_delim = d;
    tick();
    bus.i_job_valid = 1'b0;
    bus.i_job_delim = 1'b0;
  endtask

  task automatic wait_req(input int sh, input int mh, input string tag);
    int k = 0;
    while (!bus.o_match_req && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_req"}, 64'(bus.o_match_req), 64'd1);
    chk({tag, "_seq_head"}, 64'(bus.o_seq_head_ptr), 64'(sh));
    chk({tag, "_match_head"}, 64'(bus.o_match_head_ptr), 64'(mh));
    chk({tag, "_no_seq"}, 64'(bus.o_seq_valid), 64'd0);
  endtask

  // Summary returns a couple of cycles after the request, as the pipeline would.
  task automatic summary(input int ll, input int ml, input int off, input logic eoj,
                         input int ovl, input int mf);
    tick();
    tick();
    bus.i_summary_ll          = 8'(ll);
    bus.i_summary_ml          = 8'(ml);
    bus.i_summary_offset      = 16'(off);
    bus.i_summary_eoj         = eoj;
    bus.i_summary_overlap_len = 8'(ovl);
    bus.i_move_forward        = 6'(mf);
    bus.i_summary_done        = 1'b1;
    tick();
    bus.i_summary_done        = 1'b0;
  endtask

  task automatic collect(input int stall, input string tag);
    int   k = 0;
    seq_t e;
    while (!bus.o_seq_valid && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, 64'(bus.o_seq_valid), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_fields"}, 64'(obs_seq()), 64'(e));
      chk({tag, "_stall_no_req"}, 64'(bus.o_match_req), 64'd0);
      tick();
      chk({tag, "_stall_valid"}, 64'(bus.o_seq_valid), 64'd1);
    end
    bus.i_seq_ready = 1'b1;
    chk({tag, "_fields"}, 64'(obs_seq()), 64'(e));
    tick();
    bus.i_seq_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(bus.o_seq_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_job_valid = 1'b0;
    bus.i_job_delim = 1'b0;
    bus.i_summary_done = 1'b0;
    bus.i_summary_ll = '0;
    bus.i_summary_ml = '0;
    bus.i_summary_offset = '0;
    bus.i_summary_eoj = 1'b0;
    bus.i_summary_overlap_len = '0;
    bus.i_move_forward = '0;
    bus.i_seq_ready = 1'b0;

    repeat (3) tick();
    chk("rst_job_ready", 64'(bus.o_job_ready), 64'd1);
    chk("rst_seq_valid", 64'(bus.o_seq_valid), 64'd0);
    chk("rst_match_req", 64'(bus.o_match_req), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_ptrs", 64'({bus.o_seq_head_ptr, bus.o_match_head_ptr}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Five no-match steps, then a match at match_head 5.
    start_job(1'b0);
    for (int m = 0; m < 5; m++) begin
      wait_req(0, m, "step");
      summary(m + 1, 0, 0, 1'b0, 0, 0);
    end
    wait_req(0, 5, "match5");
    exp_q.push_back('{ll: 8'd5, ml: 8'd10, off: 16'd100, eoj: 1'b0, delim: 1'b0});
    summary(5, 10, 100, 1'b0, 0, 15);
    collect(0, "seq_match");
    wait_req(15, 15, "after_match");

    // End of job with overlap 3, sink stalls for 5 cycles.
    exp_q.push_back('{ll: 8'd2, ml: 8'd20, off: 16'd7, eoj: 1'b1, delim: 1'b0});
    summary(2, 20, 7, 1'b1, 3, 0);
    collect(5, "seq_eoj_stall");
    start_job(1'b0);
    wait_req(3, 3, "carry3");

    // Walk to seq_head 50 / match_head 63, then tail flush.
    exp_q.push_back('{ll: 8'd0, ml: 8'd1, off: 16'd5, eoj: 1'b0, delim: 1'b0});
    summary(0, 1, 5, 1'b0, 0, 47);
    collect(0, "seq_to50");
    for (int m = 50; m < 63; m++) begin
      wait_req(50, m, "walk");
      summary(0, 0, 0, 1'b0, 0, 0);
    end
    wait_req(50, 63, "edge63");
    exp_q.push_back('{ll: 8'd14, ml: 8'd0, off: 16'd0, eoj: 1'b1, delim: 1'b0});
    summary(0, 0, 0, 1'b0, 0, 0);
    collect(0, "seq_tail");
    start_job(1'b0);
    wait_req(0, 0, "after_tail");

    // Overlap 70 skips the next job entirely, leaving carry 6.
    exp_q.push_back('{ll: 8'd1, ml: 8'd2, off: 16'd3, eoj: 1'b1, delim: 1'b0});
    summary(1, 2, 3, 1'b1, 70, 0);
    collect(0, "seq_ovl70");
    start_job(1'b0);
    chk("skip_no_req", 64'(bus.o_match_req), 64'd0);
    chk("skip_not_ready", 64'(bus.o_job_ready), 64'd0);
    chk("skip_no_seq", 64'(bus.o_seq_valid), 64'd0);
    tick();
    chk("skip_ready_again", 64'(bus.o_job_ready), 64'd1);
    start_job(1'b0);
    wait_req(6, 6, "carry6");

    // Delim job with carry >= 64 clears carry.
    exp_q.push_back('{ll: 8'd1, ml: 8'd1, off: 16'd1, eoj: 1'b1, delim: 1'b0});
    summary(1, 1, 1, 1'b1, 80, 0);
    collect(0, "seq_ovl80");
    start_job(1'b1);
    chk("skip_delim_no_req", 64'(bus.o_match_req), 64'd0);
    tick();
    start_job(1'b0);
    wait_req(0, 0, "delim_skip_clear");

    // Delim job emits delim=1 and drops its overlap.
    exp_q.push_back('{ll: 8'd4, ml: 8'd4, off: 16'd4, eoj: 1'b1, delim: 1'b0});
    summary(4, 4, 4, 1'b1, 5, 0);
    collect(0, "seq_ovl5");
    start_job(1'b1);
    wait_req(5, 5, "carry5");
    chk("delim_latched", 64'(bus.o_delim), 64'd1);
    exp_q.push_back('{ll: 8'd6, ml: 8'd7, off: 16'd8, eoj: 1'b1, delim: 1'b1});
    summary(6, 7, 8, 1'b1, 9, 0);
    collect(0, "seq_delim");
    start_job(1'b0);
    wait_req(0, 0, "delim_clear");

    // Reset while waiting on a summary; the late summary must be ignored.
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_seq_valid", 64'(bus.o_seq_valid), 64'd0);
    chk("arst_job_ready", 64'(bus.o_job_ready), 64'd1);
    chk("arst_busy", 64'(bus.o_busy), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.i_summary_ll = 8'd3;
    bus.i_summary_ml = 8'd5;
    bus.i_summary_offset = 16'd9;
    bus.i_summary_eoj = 1'b1;
    bus.i_summary_done = 1'b1;
    tick();
    bus.i_summary_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_seq", 64'(bus.o_seq_valid), 64'd0);
      chk("post_rst_idle", 64'(bus.o_job_ready), 64'd1);
      tick();
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
